// File: rtl/spike_pkg.sv
// Shared width derivations and slice helpers for the spike line packer.
package spike_pkg;

  // Bits needed to index n items (minimum 1 so zero-width vectors never appear).
  function automatic int clog2w(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int line_w(input int img_width, input int time_steps);
    return img_width * time_steps;
  endfunction

  function automatic int beat_w(input int lanes, input int time_steps);
    return lanes * time_steps;
  endfunction

  function automatic int pix_cnt_w(input int img_width);
    return clog2w(img_width);
  endfunction

  function automatic int row_w(input int img_height);
    return clog2w(img_height);
  endfunction

  function automatic int popcnt_w(input int img_width, input int time_steps);
    return clog2w(img_width * time_steps + 1);
  endfunction

  // Bit offset of a pixel slice inside a packed line.
  function automatic int pix_off(input int pix, input int time_steps);
    return pix * time_steps;
  endfunction

endpackage

// File: rtl/spike_line_buf.sv
// One half of the ping-pong line store: line register, full/last flags,
// write-at-pixel-offset, clear on handoff. Optional running spike count
// when SPIKE_POPCNT_EN is defined.
module spike_line_buf
  import spike_pkg::*;
#(
  parameter int TIME_STEPS = 4,
  parameter int IMG_WIDTH  = 32,
  parameter int LANES      = 1
) (
  input  logic                                         s_clk,
  input  logic                                         s_rst_n,
  input  logic                                         wr_en,
  input  logic [pix_cnt_w(IMG_WIDTH)-1:0]              wr_pix,
  input  logic [beat_w(LANES, TIME_STEPS)-1:0]         wr_data,
  input  logic                                         close,
  input  logic                                         close_last,
  input  logic                                         clr,
  output logic [line_w(IMG_WIDTH, TIME_STEPS)-1:0]     line,
  output logic                                         full,
  output logic                                         last
`ifdef SPIKE_POPCNT_EN
  ,
  output logic [popcnt_w(IMG_WIDTH, TIME_STEPS)-1:0]   popcnt
`endif
);

  localparam int BEAT_W = beat_w(LANES, TIME_STEPS);

  // Line contents and flags; clearing on handoff keeps early-closed tails at zero.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      line <= '0;
      full <= 1'b0;
      last <= 1'b0;
    end else if (clr) begin
      line <= '0;
      full <= 1'b0;
      last <= 1'b0;
    end else begin
      if (wr_en)
        line[pix_off(int'(wr_pix), TIME_STEPS) +: BEAT_W] <= wr_data;
      if (close) begin
        full <= 1'b1;
        last <= close_last;
      end
    end
  end

`ifdef SPIKE_POPCNT_EN
  localparam int POP_W = popcnt_w(IMG_WIDTH, TIME_STEPS);
  logic [POP_W-1:0] beat_pop;

  // Number of set spike bits in the incoming beat.
  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < BEAT_W; i++)
      beat_pop = beat_pop + POP_W'(wr_data[i]);
  end

  // Running spike count for the line being assembled in this half.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n)
      popcnt <= '0;
    else if (clr)
      popcnt <= '0;
    else if (wr_en)
      popcnt <= popcnt + beat_pop;
  end
`endif

endmodule

// File: rtl/spike_line_packer.sv
// Packs LANES pixels per beat of TIME_STEPS-bit spike vectors into full
// IMG_WIDTH lines through a ping-pong pair of line buffers, with row and
// frame-end tracking. Optional feature macro: SPIKE_POPCNT_EN adds the
// o_line_popcnt port with a per-line spike count.
module spike_line_packer
  import spike_pkg::*;
#(
  parameter int TIME_STEPS = 4,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int LANES      = 1
) (
  input  logic                                         s_clk,
  input  logic                                         s_rst_n,
  input  logic                                         i_spk_valid,
  output logic                                         o_spk_ready,
  input  logic [beat_w(LANES, TIME_STEPS)-1:0]         i_spk_data,
  input  logic                                         i_spk_last,
  output logic                                         o_line_valid,
  input  logic                                         i_line_ready,
  output logic [line_w(IMG_WIDTH, TIME_STEPS)-1:0]     o_line_data,
  output logic [row_w(IMG_HEIGHT)-1:0]                 o_line_row,
  output logic                                         o_line_last,
  output logic                                         o_frame_done
`ifdef SPIKE_POPCNT_EN
  ,
  output logic [popcnt_w(IMG_WIDTH, TIME_STEPS)-1:0]   o_line_popcnt
`endif
);

  localparam int LINE_W = line_w(IMG_WIDTH, TIME_STEPS);
  localparam int PIX_W  = pix_cnt_w(IMG_WIDTH);
  localparam int ROW_W  = row_w(IMG_HEIGHT);

  localparam logic [PIX_W-1:0] PIX_END  = PIX_W'(IMG_WIDTH - LANES);
  localparam logic [PIX_W-1:0] PIX_STEP = PIX_W'(LANES);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(IMG_HEIGHT - 1);

  logic              rdy_en;
  logic [PIX_W-1:0]  pix_cnt;
  logic              wr_sel;
  logic              rd_sel;
  logic [ROW_W-1:0]  wr_row;
  logic [ROW_W-1:0]  row_cnt;

  logic [1:0]        buf_full;
  logic [1:0]        buf_last;
  logic [LINE_W-1:0] buf_line0;
  logic [LINE_W-1:0] buf_line1;

  logic              accept;
  logic              close;
  logic              close_last;
  logic              hand;

  // Handshake decode; ready comes from registered state only.
  always_comb begin
    o_spk_ready  = rdy_en & ~buf_full[wr_sel];
    accept       = i_spk_valid & o_spk_ready;
    close        = accept & ((pix_cnt == PIX_END) | i_spk_last);
    close_last   = i_spk_last | (wr_row == ROW_END);
    o_line_valid = buf_full[rd_sel];
    o_line_last  = buf_last[rd_sel];
    o_line_data  = rd_sel ? buf_line1 : buf_line0;
    o_line_row   = row_cnt;
    hand         = o_line_valid & i_line_ready;
  end

  // Write-side pixel/row position, read-side row, buffer selects and frame pulse.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rdy_en       <= 1'b0;
      pix_cnt      <= '0;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      wr_row       <= '0;
      row_cnt      <= '0;
      o_frame_done <= 1'b0;
    end else begin
      rdy_en       <= 1'b1;
      o_frame_done <= hand & o_line_last;
      if (accept) begin
        if (close) begin
          pix_cnt <= '0;
          wr_sel  <= ~wr_sel;
          wr_row  <= close_last ? '0 : wr_row + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + PIX_STEP;
        end
      end
      if (hand) begin
        rd_sel  <= ~rd_sel;
        row_cnt <= o_line_last ? '0 : row_cnt + 1'b1;
      end
    end
  end

`ifdef SPIKE_POPCNT_EN
  logic [popcnt_w(IMG_WIDTH, TIME_STEPS)-1:0] buf_pop0;
  logic [popcnt_w(IMG_WIDTH, TIME_STEPS)-1:0] buf_pop1;
  assign o_line_popcnt = rd_sel ? buf_pop1 : buf_pop0;
`endif

  spike_line_buf #(
    .TIME_STEPS (TIME_STEPS),
    .IMG_WIDTH  (IMG_WIDTH),
    .LANES      (LANES)
  ) u_buf0 (
    .s_clk      (s_clk),
    .s_rst_n    (s_rst_n),
    .wr_en      (accept & ~wr_sel),
    .wr_pix     (pix_cnt),
    .wr_data    (i_spk_data),
    .close      (close & ~wr_sel),
    .close_last (close_last),
    .clr        (hand & ~rd_sel),
    .line       (buf_line0),
    .full       (buf_full[0]),
    .last       (buf_last[0])
`ifdef SPIKE_POPCNT_EN
    ,
    .popcnt     (buf_pop0)
`endif
  );

  spike_line_buf #(
    .TIME_STEPS (TIME_STEPS),
    .IMG_WIDTH  (IMG_WIDTH),
    .LANES      (LANES)
  ) u_buf1 (
    .s_clk      (s_clk),
    .s_rst_n    (s_rst_n),
    .wr_en      (accept & wr_sel),
    .wr_pix     (pix_cnt),
    .wr_data    (i_spk_data),
    .close      (close & wr_sel),
    .close_last (close_last),
    .clr        (hand & rd_sel),
    .line       (buf_line1),
    .full       (buf_full[1]),
    .last       (buf_last[1])
`ifdef SPIKE_POPCNT_EN
    ,
    .popcnt     (buf_pop1)
`endif
  );

endmodule
